// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor: data width, memory functions and DMEM controller enums.
package simple_processor_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int DMEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    STORE = 2'b01
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ERR  = 2'b10
  } dmem_ctrl_state_t;

  typedef enum logic {
    ID_CORE = 1'b0,
    ID_DBG  = 1'b1
  } dmem_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 = core, bit 1 = dbg.
// Latency: combinational grant, last-grant register updates on upd_i.
// Backpressure: no grant is stored; requesters stay pending until upd_i takes them.
module rr_arb2
  import simple_processor_pkg::*;
(
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  dmem_id_t last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == ID_DBG) ? 2'b01 : 2'b10;
    end
  end

  // Reset to "dbg granted last" so core wins the first tie.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      last_q <= ID_DBG;
    end else if (upd_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1] ? ID_DBG : ID_CORE;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Shares the single DMEM port between core and dbg, one access at a time, with timeout abort.
// Latency: accept in cycle 0, dmem_req_o from cycle 1, done one cycle after ack (min 2 cycles/txn).
// Backpressure: acc_o only while IDLE; requesters hold valid and fields until accepted.
module dmem_ctrl
  import simple_processor_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  core_valid_i,
  input  func_t                 core_func_i,
  input  logic [DATA_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_acc_o,
  output logic                  core_done_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_err_o,
  input  logic                  dbg_valid_i,
  input  func_t                 dbg_func_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_acc_o,
  output logic                  dbg_done_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_err_o,
  output logic                  dmem_req_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0] dmem_rd_i,
  input  logic                  dmem_ack_i,
  output logic                  busy_o
);

  dmem_ctrl_state_t      state_q, state_d;
  func_t                 func_q;
  dmem_id_t              owner_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  req_q, we_q;
  logic                  core_done_q, dbg_done_q, core_err_q, dbg_err_q;
  logic [DATA_WIDTH-1:0] core_rdata_q, dbg_rdata_q;

  logic [1:0]            gnt;
  logic                  acc_any, win_legal, fin_ok, fin_err, fin;
  dmem_id_t              win_id, done_id;
  func_t                 win_func;
  logic [DATA_WIDTH-1:0] win_addr, win_wdata;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .req_i   ({dbg_valid_i, core_valid_i} & {2{state_q == IDLE}}),
    .upd_i   (acc_any),
    .gnt_o   (gnt)
  );

  assign acc_any   = |gnt;
  assign win_id    = gnt[1] ? ID_DBG : ID_CORE;
  assign win_func  = gnt[1] ? dbg_func_i : core_func_i;
  assign win_addr  = gnt[1] ? dbg_addr_i : core_addr_i;
  assign win_wdata = gnt[1] ? dbg_wdata_i : core_wdata_i;
  assign win_legal = (win_func == LOAD) || (win_func == STORE);

  always_comb begin
    state_d = state_q;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc_any) begin
          state_d = win_legal ? BUSY : ERR;
          // An illegal request reports its error during the ERR cycle itself.
          fin_err = !win_legal;
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          state_d = IDLE;
          fin_ok  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          fin_err = 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fin     = fin_ok || fin_err;
  assign done_id = (state_q == IDLE) ? win_id : owner_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= IDLE;
      func_q       <= LOAD;
      owner_q      <= ID_CORE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      core_done_q  <= 1'b0;
      dbg_done_q   <= 1'b0;
      core_err_q   <= 1'b0;
      dbg_err_q    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc_any) begin
        func_q  <= win_func;
        owner_q <= win_id;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        cnt_q   <= '0;
      end else if ((state_q == BUSY) && (cnt_q != CNT_W'(TIMEOUT))) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // DMEM strobes come straight from flops so the macro never sees a decode glitch.
      req_q <= (state_d == BUSY);
      we_q  <= (state_d == BUSY) && ((acc_any ? win_func : func_q) == STORE);

      core_done_q <= fin && (done_id == ID_CORE);
      dbg_done_q  <= fin && (done_id == ID_DBG);
      if (fin && (done_id == ID_CORE)) begin
        core_err_q   <= fin_err;
        core_rdata_q <= (fin_ok && (func_q == LOAD)) ? dmem_rd_i : '0;
      end
      if (fin && (done_id == ID_DBG)) begin
        dbg_err_q   <= fin_err;
        dbg_rdata_q <= (fin_ok && (func_q == LOAD)) ? dmem_rd_i : '0;
      end
    end
  end

  assign core_acc_o   = gnt[0];
  assign dbg_acc_o    = gnt[1];
  assign core_done_o  = core_done_q;
  assign dbg_done_o   = dbg_done_q;
  assign core_err_o   = core_err_q;
  assign dbg_err_o    = dbg_err_q;
  assign core_rdata_o = core_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized bench for dmem_ctrl against a memory/arbitration reference model.
module tb_dmem_ctrl;
  import simple_processor_pkg::*;

  localparam int TO = 4;
  localparam logic [1:0] F_LD = 2'b00;
  localparam logic [1:0] F_ST = 2'b01;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        core_valid_i, dbg_valid_i;
  func_t       core_func_i, dbg_func_i;
  logic [31:0] core_addr_i, core_wdata_i, dbg_addr_i, dbg_wdata_i;
  logic        core_acc_o, core_done_o, core_err_o, dbg_acc_o, dbg_done_o, dbg_err_o;
  logic [31:0] core_rdata_o, dbg_rdata_o;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i, busy_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rd_i;

  int          tests, fails, cyc;
  logic [1:0]  rf [2];
  logic [31:0] ra [2];
  logic [31:0] rw [2];
  logic [31:0] mem [logic [31:0]];
  bit          last;
  int          acc_cyc [$];
  bit          acc_who [$];

  always #5 clk_i = ~clk_i;

  assign core_func_i  = func_t'(rf[0]);
  assign core_addr_i  = ra[0];
  assign core_wdata_i = rw[0];
  assign dbg_func_i   = func_t'(rf[1]);
  assign dbg_addr_i   = ra[1];
  assign dbg_wdata_i  = rw[1];

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .core_valid_i(core_valid_i), .core_func_i(core_func_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_acc_o(core_acc_o), .core_done_o(core_done_o),
    .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .dbg_valid_i(dbg_valid_i), .dbg_func_i(dbg_func_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_acc_o(dbg_acc_o), .dbg_done_o(dbg_done_o),
    .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rd_i(dmem_rd_i), .dmem_ack_i(dmem_ack_i),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Follows one accepted request to its completion; ends in the first cycle a new accept may occur.
  task automatic do_txn(input bit w, input int dly);
    logic [31:0] exp_rd;
    bit          legal, acked;
    legal = (rf[w] == F_LD) || (rf[w] == F_ST);
    tick();
    if (w) dbg_valid_i = 1'b0; else core_valid_i = 1'b0;
    #1;
    if (!legal) begin
      chk("ill_req", dmem_req_o, 0);
      chk("ill_busy", busy_o, 1);
      chk("ill_done", w ? dbg_done_o : core_done_o, 1);
      chk("ill_err", w ? dbg_err_o : core_err_o, 1);
      chk("ill_rdata", w ? dbg_rdata_o : core_rdata_o, 0);
      chk("ill_other_done", w ? core_done_o : dbg_done_o, 0);
      tick();
      chk("ill_req_after", dmem_req_o, 0);
      chk("ill_done_after", w ? dbg_done_o : core_done_o, 0);
      return;
    end
    acked  = 1'b0;
    exp_rd = 32'h0;
    for (int c = 1; c <= TO && !acked; c++) begin
      chk("busy_req", dmem_req_o, 1);
      chk("busy_flag", busy_o, 1);
      chk("busy_addr", dmem_addr_o, ra[w]);
      chk("busy_we", dmem_we_o, (rf[w] == F_ST));
      chk("busy_wdata", dmem_wdata_o, rw[w]);
      chk("busy_no_done", core_done_o | dbg_done_o, 0);
      chk("busy_no_acc", core_acc_o | dbg_acc_o, 0);
      if (c == dly + 1) begin
        dmem_ack_i = 1'b1;
        if (rf[w] == F_LD) begin
          dmem_rd_i = mem_rd(ra[w]);
          exp_rd    = mem_rd(ra[w]);
        end else begin
          dmem_rd_i = $urandom;
        end
        acked = 1'b1;
      end
      tick();
      dmem_ack_i = 1'b0;
      dmem_rd_i  = $urandom;
    end
    if (acked && rf[w] == F_ST) mem[ra[w]] = rw[w];
    chk("done", w ? dbg_done_o : core_done_o, 1);
    chk("done_err", w ? dbg_err_o : core_err_o, !acked);
    chk("done_rdata", w ? dbg_rdata_o : core_rdata_o, exp_rd);
    chk("done_other", w ? core_done_o : dbg_done_o, 0);
    chk("done_req_low", dmem_req_o, 0);
  endtask

  // Raises the requesters in pat and serves them; expected winner favours the one not granted last.
  task automatic run_round(input logic [1:0] pat, input int dmin, input int dmax);
    logic [1:0] pend;
    bit         w;
    pend = pat;
    core_valid_i = pat[0];
    dbg_valid_i  = pat[1];
    while (pend != 2'b00) begin
      #1;
      if (pend == 2'b11) w = !last; else w = pend[1];
      chk("acc_core", core_acc_o, !w);
      chk("acc_dbg", dbg_acc_o, w);
      acc_cyc.push_back(cyc);
      acc_who.push_back(dbg_acc_o);
      last = w;
      pend[w] = 1'b0;
      do_txn(w, $urandom_range(dmax, dmin));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; last = 1'b1;
    arst_ni = 1'b0;
    core_valid_i = 1'b0; dbg_valid_i = 1'b0;
    dmem_ack_i = 1'b0; dmem_rd_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      rf[i] = F_LD; ra[i] = 32'h0; rw[i] = 32'h0;
    end

    #12;
    chk("rst_core_acc", core_acc_o, 0);
    chk("rst_dbg_acc", dbg_acc_o, 0);
    chk("rst_done", {core_done_o, dbg_done_o, core_err_o, dbg_err_o}, 0);
    chk("rst_core_rdata", core_rdata_o, 0);
    chk("rst_dbg_rdata", dbg_rdata_o, 0);
    chk("rst_dmem_addr", dmem_addr_o, 0);
    chk("rst_dmem_wdata", dmem_wdata_o, 0);
    chk("rst_strobes", {dmem_req_o, dmem_we_o, busy_o}, 0);
    arst_ni = 1'b1;
    tick();

    // Simultaneous stores: core first, then dbg, two cycles apart.
    acc_cyc.delete(); acc_who.delete();
    rf[0] = F_ST; ra[0] = 32'h100; rw[0] = 32'h11;
    rf[1] = F_ST; ra[1] = 32'h104; rw[1] = 32'h22;
    run_round(2'b11, 0, 0);
    chk("st_first_is_core", acc_who[0], 0);
    chk("st_second_is_dbg", acc_who[1], 1);
    chk("st_accept_gap", acc_cyc[1] - acc_cyc[0], 2);

    // Four back-to-back contested requests alternate.
    acc_cyc.delete(); acc_who.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) begin
        rf[i] = ($urandom_range(0, 1) != 0) ? F_ST : F_LD;
        ra[i] = 32'h200 + 32'(4 * (2 * r + i));
        rw[i] = $urandom;
      end
      run_round(2'b11, 0, 0);
    end
    for (int i = 0; i < 4; i++) chk("rr_order", acc_who[i], i % 2);
    for (int i = 1; i < 4; i++) chk("rr_gap", acc_cyc[i] - acc_cyc[i-1], 2);

    // Core load, ack in cycle 1, done in cycle 2.
    mem[32'h10] = 32'hDEADBEEF;
    rf[0] = F_LD; ra[0] = 32'h10; rw[0] = 32'h0;
    run_round(2'b01, 0, 0);
    chk("ld_rdata", core_rdata_o, 32'hDEADBEEF);

    // No ack: error completion in cycle TO+1, then a stray ack is ignored.
    rf[0] = F_LD; ra[0] = 32'h10; rw[0] = 32'h5;
    run_round(2'b01, 99, 99);
    tick();
    dmem_ack_i = 1'b1; dmem_rd_i = 32'hFFFF_FFFF;
    tick();
    dmem_ack_i = 1'b0;
    chk("stray_done", core_done_o | dbg_done_o, 0);
    chk("stray_busy", busy_o, 0);
    chk("stray_req", dmem_req_o, 0);
    chk("stray_rdata_hold", core_rdata_o, 0);
    chk("stray_err_hold", core_err_o, 1);

    // Illegal function from dbg.
    rf[1] = 2'b11; ra[1] = 32'h300; rw[1] = 32'h33;
    run_round(2'b10, 0, 0);

    // Reset while BUSY loses the access.
    rf[0] = F_ST; ra[0] = 32'h40; rw[0] = 32'hA5A5;
    core_valid_i = 1'b1;
    #1;
    chk("mid_rst_acc", core_acc_o, 1);
    tick();
    core_valid_i = 1'b0;
    #1;
    chk("mid_rst_req_before", dmem_req_o, 1);
    arst_ni = 1'b0;
    #1;
    chk("mid_rst_req_drop", dmem_req_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    tick();
    chk("mid_rst_no_done", core_done_o | dbg_done_o, 0);
    arst_ni = 1'b1;
    last = 1'b1;
    tick();
    chk("mid_rst_no_done2", core_done_o | dbg_done_o, 0);
    rf[0] = F_LD; ra[0] = 32'h10;
    run_round(2'b01, 1, 1);

    // Randomized traffic against the memory model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 9))
          0:       rf[i] = 2'($urandom_range(2, 3));
          1, 2, 3, 4: rf[i] = F_LD;
          default: rf[i] = F_ST;
        endcase
        ra[i] = 32'($urandom_range(0, 7)) << 2;
        rw[i] = $urandom;
      end
      run_round(2'($urandom_range(1, 3)), 0, 5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
